// File: rtl/match_judge.sv
// Pair judge for a 6x6 memory board: checks two selected cards for equal type and
// a clear straight-line path (all cells between them removed), then pulses ms or mf.
module match_judge #(
  parameter int TYPE_W = 3,
  parameter int PAIRS  = 18
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [35:0]           sel_bus,
  input  logic [35:0]           hidden_bus,
  input  logic [36*TYPE_W-1:0]  type_bus,
  output logic                  ms,
  output logic                  mf,
  output logic                  busy,
  output logic [4:0]            pairs_left,
  output logic                  win,
  output logic [2:0]            state_dbg
);

  // Protocol: a judgement starts when IDLE sees a valid selection (count >= 2); ms/mf
  // is a one-cycle response, and the next judgement waits until the selection drops below 2.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOCATE = 3'd1,
    S_CHECK  = 3'd2,
    S_SCAN   = 3'd3,
    S_OK     = 3'd4,
    S_FAIL   = 3'd5,
    S_WAIT   = 3'd6
  } state_e;

  state_e              state_q, state_d;
  logic [35:0]         mask_q, mask_d;
  logic [5:0]          a_q, a_d, b_q, b_d, k_q, k_d;
  logic [2:0]          ra_q, ra_d, ca_q, ca_d, rb_q, rb_d, cb_q, cb_d;
  logic [TYPE_W-1:0]   ta_q, ta_d, tb_q, tb_d;
  logic                vert_q, vert_d;
  logic [4:0]          pairs_q, pairs_d;
  logic                ms_q, ms_d, mf_q, mf_d, busy_q, busy_d;

  logic [35:0] valid;
  logic [5:0]  sel_cnt;
  logic [5:0]  lo_idx, hi_idx, k_next;
  logic [2:0]  lo_row, lo_col, hi_row, hi_col, dcol, drow;

  assign valid   = sel_bus & ~hidden_bus;
  assign sel_cnt = 6'($countones(valid));
  assign dcol    = cb_q - ca_q;
  assign drow    = rb_q - ra_q;
  assign k_next  = vert_q ? k_q + 6'd6 : k_q + 6'd1;

  // Lowest/highest set card of the selection captured when the judgement started.
  always_comb begin
    lo_idx = '0;
    lo_row = '0;
    lo_col = '0;
    hi_idx = '0;
    hi_row = '0;
    hi_col = '0;
    for (int r = 5; r >= 0; r--) begin
      for (int c = 5; c >= 0; c--) begin
        if (mask_q[r*6+c]) begin
          lo_idx = 6'(r*6+c);
          lo_row = 3'(r);
          lo_col = 3'(c);
        end
      end
    end
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 6; c++) begin
        if (mask_q[r*6+c]) begin
          hi_idx = 6'(r*6+c);
          hi_row = 3'(r);
          hi_col = 3'(c);
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    a_d     = a_q;
    b_d     = b_q;
    k_d     = k_q;
    ra_d    = ra_q;
    ca_d    = ca_q;
    rb_d    = rb_q;
    cb_d    = cb_q;
    ta_d    = ta_q;
    tb_d    = tb_q;
    vert_d  = vert_q;
    pairs_d = pairs_q;
    case (state_q)
      S_IDLE: begin
        if (sel_cnt == 6'd2) begin
          state_d = S_LOCATE;
          mask_d  = valid;
        end else if (sel_cnt > 6'd2) begin
          state_d = S_FAIL;
        end
      end
      S_LOCATE: begin
        a_d     = lo_idx;
        b_d     = hi_idx;
        ra_d    = lo_row;
        ca_d    = lo_col;
        rb_d    = hi_row;
        cb_d    = hi_col;
        ta_d    = type_bus[lo_idx*TYPE_W +: TYPE_W];
        tb_d    = type_bus[hi_idx*TYPE_W +: TYPE_W];
        state_d = S_CHECK;
      end
      S_CHECK: begin
        // b is the higher index, so dcol (same row) and drow are never negative.
        if (ta_q != tb_q) begin
          state_d = S_FAIL;
        end else if (ra_q == rb_q) begin
          if (dcol == 3'd1) state_d = S_OK;
          else begin
            state_d = S_SCAN;
            k_d     = a_q + 6'd1;
            vert_d  = 1'b0;
          end
        end else if (ca_q == cb_q) begin
          if (drow == 3'd1) state_d = S_OK;
          else begin
            state_d = S_SCAN;
            k_d     = a_q + 6'd6;
            vert_d  = 1'b1;
          end
        end else begin
          state_d = S_FAIL;
        end
      end
      S_SCAN: begin
        if (!hidden_bus[k_q])     state_d = S_FAIL;
        else if (k_next == b_q)   state_d = S_OK;
        else                      k_d     = k_next;
      end
      S_OK: begin
        pairs_d = (pairs_q == 5'd0) ? 5'd0 : pairs_q - 5'd1;
        state_d = S_WAIT;
      end
      S_FAIL: state_d = S_WAIT;
      S_WAIT: begin
        if (sel_cnt < 6'd2) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    ms_d   = (state_d == S_OK);
    mf_d   = (state_d == S_FAIL);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      k_q     <= '0;
      ra_q    <= '0;
      ca_q    <= '0;
      rb_q    <= '0;
      cb_q    <= '0;
      ta_q    <= '0;
      tb_q    <= '0;
      vert_q  <= 1'b0;
      pairs_q <= 5'(PAIRS);
      ms_q    <= 1'b0;
      mf_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      a_q     <= a_d;
      b_q     <= b_d;
      k_q     <= k_d;
      ra_q    <= ra_d;
      ca_q    <= ca_d;
      rb_q    <= rb_d;
      cb_q    <= cb_d;
      ta_q    <= ta_d;
      tb_q    <= tb_d;
      vert_q  <= vert_d;
      pairs_q <= pairs_d;
      ms_q    <= ms_d;
      mf_q    <= mf_d;
      busy_q  <= busy_d;
    end
  end

  assign ms         = ms_q;
  assign mf         = mf_q;
  assign busy       = busy_q;
  assign pairs_left = pairs_q;
  assign win        = (pairs_q == 5'd0);
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_match_judge.sv
// Bench for match_judge: fixed vector table, hand-written multi-cycle sequences and
// random boards checked against a path/type reference model.
module tb_match_judge;
  localparam int TW = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [35:0]       sel_bus = '0;
  logic [35:0]       hidden_bus = '0;
  logic [36*TW-1:0]  type_bus = '0;
  logic              ms, mf, busy, win;
  logic [4:0]        pairs_left;
  logic [2:0]        state_dbg;

  match_judge #(.TYPE_W(TW), .PAIRS(18)) dut (
    .clk        (clk),
    .rst        (rst),
    .sel_bus    (sel_bus),
    .hidden_bus (hidden_bus),
    .type_bus   (type_bus),
    .ms         (ms),
    .mf         (mf),
    .busy       (busy),
    .pairs_left (pairs_left),
    .win        (win),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [35:0]      sel;
    logic [35:0]      hid;
    logic [36*TW-1:0] typ;
    int               kind;   // 0 none, 1 ms, 2 mf
    int               lat;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int exp_pairs = 18;
  logic [7:0] exp_q[$];

  int obs_cyc, obs_kind, obs_lat, obs_extra, obs_both, obs_busy1;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic logic [35:0] b2(input int i, input int j);
    return (36'd1 << i) | (36'd1 << j);
  endfunction

  function automatic logic [36*TW-1:0] ty(input int i0, input int t0, input int i1, input int t1);
    logic [36*TW-1:0] v = '0;
    v[i0*TW +: TW] = TW'(t0);
    v[i1*TW +: TW] = TW'(t1);
    return v;
  endfunction

  // Reference: list the live selected cards, then walk the straight path between them.
  function automatic void ref_judge(input logic [35:0] sel, input logic [35:0] hid,
                                    input logic [36*TW-1:0] typ, output int kind, output int lat);
    int idx[$];
    int path[$];
    int a, b;
    for (int i = 0; i < 36; i++) if (sel[i] && !hid[i]) idx.push_back(i);
    kind = 0;
    lat  = 0;
    if (idx.size() > 2) begin kind = 2; lat = 1; return; end
    if (idx.size() < 2) return;
    a = idx[0];
    b = idx[1];
    if (typ[a*TW +: TW] != typ[b*TW +: TW]) begin kind = 2; lat = 3; return; end
    if (a / 6 == b / 6) begin
      for (int c = a % 6 + 1; c < b % 6; c++) path.push_back((a / 6) * 6 + c);
    end else if (a % 6 == b % 6) begin
      for (int r = a / 6 + 1; r < b / 6; r++) path.push_back(r * 6 + a % 6);
    end else begin
      kind = 2; lat = 3; return;
    end
    kind = 1;
    lat  = 3 + path.size();
    for (int j = 0; j < path.size(); j++) begin
      if (!hid[path[j]]) begin kind = 2; lat = 4 + j; return; end
    end
  endfunction

  task automatic start_obs();
    obs_cyc = 0; obs_kind = 0; obs_lat = 0; obs_extra = 0; obs_both = 0; obs_busy1 = 0;
  endtask

  task automatic step_obs(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      obs_cyc++;
      if (obs_cyc == 1) obs_busy1 = int'(busy);
      if (ms && mf) obs_both = 1;
      if (ms || mf) begin
        if (obs_kind == 0) begin
          obs_kind = ms ? 1 : 2;
          obs_lat  = obs_cyc;
        end else obs_extra++;
      end
    end
  endtask

  task automatic drive(input logic [35:0] sel, input logic [35:0] hid, input logic [36*TW-1:0] typ);
    @(negedge clk);
    sel_bus    = sel;
    hidden_bus = hid;
    type_bus   = typ;
  endtask

  task automatic finish_judge(input string name);
    logic [7:0] e;
    int ek, el, n;
    e  = exp_q.pop_front();
    ek = int'(e[7:4]);
    el = int'(e[3:0]);
    check({name, "_kind"}, obs_kind, ek);
    check({name, "_lat"}, obs_lat, el);
    check({name, "_extra_pulse"}, obs_extra, 0);
    check({name, "_ms_mf_both"}, obs_both, 0);
    check({name, "_busy_c1"}, obs_busy1, (ek != 0) ? 1 : 0);
    if (ek == 1 && exp_pairs > 0) exp_pairs--;
    @(negedge clk);
    sel_bus = '0;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (busy && n < 10);
    check({name, "_idle"}, int'(busy), 0);
    check({name, "_pairs"}, int'(pairs_left), exp_pairs);
    check({name, "_win"}, int'(win), (exp_pairs == 0) ? 1 : 0);
  endtask

  task automatic run_vec(input logic [35:0] sel, input logic [35:0] hid, input logic [36*TW-1:0] typ,
                         input int kind, input int lat, input string name);
    drive(sel, hid, typ);
    start_obs();
    exp_q.push_back(8'(kind * 16 + lat));
    step_obs(14);
    finish_judge(name);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t vecs[14];
    int   kind, lat;
    logic [35:0] sel, hid;
    logic [36*TW-1:0] typ;
    logic [63:0] r64;
    int a, b;

    vecs[0]  = '{b2(0, 1),  36'd0,               ty(0, 5, 1, 5), 1, 3};
    vecs[1]  = '{b2(0, 3),  b2(1, 2),            '0,             1, 5};
    vecs[2]  = '{b2(0, 3),  36'd1 << 1,          '0,             2, 5};
    vecs[3]  = '{b2(0, 6),  36'd0,               ty(0, 1, 6, 2), 2, 3};
    vecs[4]  = '{b2(0, 7),  36'd0,               '0,             2, 3};
    vecs[5]  = '{b2(0, 1) | (36'd1 << 2), 36'd0, '0,             2, 1};
    vecs[6]  = '{b2(0, 12), 36'd1 << 6,          '0,             1, 4};
    vecs[7]  = '{b2(0, 12), 36'd0,               '0,             2, 4};
    vecs[8]  = '{b2(0, 1) | (36'd1 << 5), b2(1, 2) | b2(3, 4), '0, 1, 7};
    vecs[9]  = '{b2(0, 1),  36'd1 << 1,          '0,             0, 0};
    vecs[10] = '{b2(29, 35), 36'd0,              '0,             1, 3};
    vecs[11] = '{b2(30, 35), b2(31, 32) | b2(33, 34), '0,        1, 7};
    vecs[12] = '{b2(0, 2),  36'd1 << 1,          ty(0, 3, 2, 4), 2, 3};
    vecs[13] = '{b2(5, 6),  36'd0,               '0,             2, 3};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ms", int'(ms), 0);
    check("rst_mf", int'(mf), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_pairs", int'(pairs_left), 18);
    check("rst_win", int'(win), 0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 14; i++)
      run_vec(vecs[i].sel, vecs[i].hid, vecs[i].typ, vecs[i].kind, vecs[i].lat, $sformatf("vec%0d", i));

    // Selection dropped during LOCATE must not abort the judgement
    drive(b2(0, 1), 36'd0, '0);
    start_obs();
    exp_q.push_back(8'(1 * 16 + 3));
    step_obs(1);
    @(negedge clk);
    sel_bus = '0;
    step_obs(13);
    finish_judge("sel_drop");

    // SCAN reads hidden_bus live: card 2 reappears while card 1 is examined
    drive(b2(0, 3), b2(1, 2), '0);
    start_obs();
    exp_q.push_back(8'(2 * 16 + 5));
    step_obs(3);
    @(negedge clk);
    hidden_bus[2] = 1'b0;
    step_obs(11);
    finish_judge("live_hidden");

    // Random boards
    for (int t = 0; t < 150; t++) begin
      a = $urandom_range(0, 35);
      case ($urandom_range(0, 2))
        0:       b = (a / 6) * 6 + $urandom_range(0, 5);
        1:       b = $urandom_range(0, 5) * 6 + a % 6;
        default: b = $urandom_range(0, 35);
      endcase
      if (b == a) b = (a + 1) % 36;
      sel = b2(a, b);
      if ($urandom_range(0, 7) == 0) sel[$urandom_range(0, 35)] = 1'b1;
      r64 = {$urandom, $urandom};
      hid = ($urandom_range(0, 1) == 0) ? r64[35:0] : ~sel;
      if ($urandom_range(0, 7) != 0) begin
        hid[a] = 1'b0;
        hid[b] = 1'b0;
      end
      typ = '0;
      for (int i = 0; i < 36; i++) typ[i*TW +: TW] = TW'($urandom_range(0, 1));
      ref_judge(sel, hid, typ, kind, lat);
      run_vec(sel, hid, typ, kind, lat, $sformatf("rand%0d", t));
    end

    // Reset asserted during SCAN
    drive(b2(0, 3), b2(1, 2), '0);
    start_obs();
    step_obs(3);
    check("scan_busy", int'(busy), 1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("arst_ms", int'(ms), 0);
    check("arst_mf", int'(mf), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_pairs", int'(pairs_left), 18);
    check("arst_win", int'(win), 0);
    exp_pairs = 18;
    sel_bus = '0;
    hidden_bus = '0;
    @(negedge clk);
    rst = 1'b1;
    start_obs();
    step_obs(10);
    check("arst_no_pulse", obs_kind, 0);
    check("arst_no_busy", obs_busy1, 0);

    // 18 successive matches reach the win condition, then one more saturates
    for (int n = 0; n < 18; n++) run_vec(b2(0, 1), 36'd0, '0, 1, 3, $sformatf("win%0d", n));
    check("win_pairs", int'(pairs_left), 0);
    check("win_flag", int'(win), 1);
    run_vec(b2(0, 1), 36'd0, '0, 1, 3, "after_win");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
